// File: rtl/spybuffer_pkg.sv
// Shared types and constants for the spy buffer event reader: word classes,
// reader states, framing tags and the tag/classification helpers.
package spybuffer_pkg;

  localparam int DATA_WIDTH_DEFAULT      = 64;
  localparam int MAX_EVENT_WORDS_DEFAULT = 4096;
  localparam logic [7:0] HEADER_TAG_DEFAULT = 8'hAB;
  localparam logic [7:0] FOOTER_TAG_DEFAULT = 8'hCD;

  typedef enum logic [1:0] {WC_DATA, WC_HEADER, WC_FOOTER, WC_META} word_class_e;

  typedef enum logic {ST_IDLE, ST_IN_EVENT} reader_state_e;

  // Tag lives in the top byte of the payload; payload is zero-extended to 64 bits.
  function automatic logic [7:0] extract_tag(input logic [63:0] payload, input int unsigned dw);
    logic [63:0] shifted;
    shifted = payload >> (dw - 8);
    return shifted[7:0];
  endfunction

  function automatic word_class_e classify_word(input logic flag, input logic [7:0] tag,
                                                input logic [7:0] hdr_tag, input logic [7:0] ftr_tag);
    if (!flag)          return WC_DATA;
    if (tag == hdr_tag) return WC_HEADER;
    if (tag == ftr_tag) return WC_FOOTER;
    return WC_META;
  endfunction

endpackage

// File: rtl/spybuffer_event_reader_skid.sv
// Two-entry registered FIFO absorbing the spy buffer read latency; entry 0 is
// always the head so the head output comes straight from a flop.
module spy_skid_fifo #(
  parameter int W = 65
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   count_q, count_d, after_pop;

  always_comb begin
    ent0_d    = ent0_q;
    ent1_d    = ent1_q;
    after_pop = count_q;
    if (pop && count_q != 2'd0) begin
      ent0_d    = ent1_q;
      after_pop = count_q - 2'd1;
    end
    count_d = after_pop;
    if (push) begin
      if (after_pop == 2'd0) ent0_d = push_data;
      else                   ent1_d = push_data;
      count_d = after_pop + 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      ent0_q  <= '0;
      ent1_q  <= '0;
      count_q <= 2'd0;
    end else begin
      ent0_q  <= ent0_d;
      ent1_q  <= ent1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = ent0_q;

endmodule

// File: rtl/spybuffer_event_reader.sv
// Drains the input spy buffer, validates header/data/footer framing and forwards
// framed events downstream. Optional counters: define EVENT_READER_STATS_EN.
module spybuffer_event_reader
  import spybuffer_pkg::*;
#(
  parameter int         DATA_WIDTH      = DATA_WIDTH_DEFAULT,
  parameter int         MAX_EVENT_WORDS = MAX_EVENT_WORDS_DEFAULT,
  parameter logic [7:0] HEADER_TAG      = HEADER_TAG_DEFAULT,
  parameter logic [7:0] FOOTER_TAG      = FOOTER_TAG_DEFAULT,
  localparam int        CW              = $clog2(MAX_EVENT_WORDS + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   buffer_read_data,
  input  logic                  buffer_empty,
  output logic                  buffer_read_enable,
  output logic [DATA_WIDTH:0]   out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  event_done,
  output logic [CW-1:0]         event_words,
  output logic                  err_orphan,
  output logic                  err_no_footer,
  output logic                  err_overflow,
  input  logic                  clear_errors
`ifdef EVENT_READER_STATS_EN
  ,
  output logic [31:0]           stat_events,
  output logic [31:0]           stat_dropped
`endif
);

  logic [1:0]          skid_count;
  logic [DATA_WIDTH:0] skid_head;
  logic                skid_pop;
  logic [63:0]         payload_ext;
  word_class_e         head_class;
  logic                head_valid, head_drop, accept;
  logic                set_orphan, set_overflow;

  logic                inflight_q;
  reader_state_e       state_q, state_d;
  logic [CW-1:0]       count_q, count_d, event_words_q, event_words_d;
  logic                event_done_q, event_done_d;
  logic                err_orphan_q, err_orphan_d;
  logic                err_no_footer_q, err_no_footer_d;
  logic                err_overflow_q, err_overflow_d;

  // Occupancy plus the read still in flight must stay below the skid depth.
  assign buffer_read_enable = reset && !buffer_empty &&
                              (({1'b0, skid_count} + {2'b00, inflight_q}) < 3'd2);

  spy_skid_fifo #(.W(DATA_WIDTH + 1)) u_skid (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight_q),
    .push_data (buffer_read_data),
    .pop       (skid_pop),
    .count     (skid_count),
    .head      (skid_head)
  );

  assign payload_ext = 64'(skid_head[DATA_WIDTH-1:0]);
  assign head_class  = classify_word(skid_head[DATA_WIDTH], extract_tag(payload_ext, DATA_WIDTH),
                                     HEADER_TAG, FOOTER_TAG);
  assign head_valid  = (skid_count != 2'd0);

  always_comb begin
    head_drop    = 1'b0;
    set_orphan   = 1'b0;
    set_overflow = 1'b0;
    if (head_valid) begin
      if (state_q == ST_IDLE) begin
        if (head_class != WC_HEADER) begin
          head_drop  = 1'b1;
          set_orphan = 1'b1;
        end
      end else if (head_class == WC_DATA && count_q >= CW'(MAX_EVENT_WORDS)) begin
        head_drop    = 1'b1;
        set_overflow = 1'b1;
      end
    end
  end

  assign out_valid = head_valid && !head_drop;
  assign out_data  = skid_head;
  assign accept    = out_valid && out_ready;
  assign skid_pop  = head_valid && (head_drop || out_ready);

  // Clear first so that an error raised in the same cycle survives.
  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    event_done_d    = 1'b0;
    event_words_d   = event_words_q;
    err_orphan_d    = clear_errors ? 1'b0 : err_orphan_q;
    err_no_footer_d = clear_errors ? 1'b0 : err_no_footer_q;
    err_overflow_d  = clear_errors ? 1'b0 : err_overflow_q;
    if (set_orphan)   err_orphan_d   = 1'b1;
    if (set_overflow) err_overflow_d = 1'b1;
    if (accept) begin
      case (head_class)
        WC_HEADER: begin
          if (state_q == ST_IN_EVENT) err_no_footer_d = 1'b1;
          state_d = ST_IN_EVENT;
          count_d = '0;
        end
        WC_DATA:   count_d = count_q + CW'(1);
        WC_FOOTER: begin
          event_done_d  = 1'b1;
          event_words_d = count_q;
          state_d       = ST_IDLE;
          count_d       = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      inflight_q      <= 1'b0;
      state_q         <= ST_IDLE;
      count_q         <= '0;
      event_done_q    <= 1'b0;
      event_words_q   <= '0;
      err_orphan_q    <= 1'b0;
      err_no_footer_q <= 1'b0;
      err_overflow_q  <= 1'b0;
    end else begin
      inflight_q      <= buffer_read_enable;
      state_q         <= state_d;
      count_q         <= count_d;
      event_done_q    <= event_done_d;
      event_words_q   <= event_words_d;
      err_orphan_q    <= err_orphan_d;
      err_no_footer_q <= err_no_footer_d;
      err_overflow_q  <= err_overflow_d;
    end
  end

  assign event_done    = event_done_q;
  assign event_words   = event_words_q;
  assign err_orphan    = err_orphan_q;
  assign err_no_footer = err_no_footer_q;
  assign err_overflow  = err_overflow_q;

`ifdef EVENT_READER_STATS_EN
  logic [31:0] stat_events_q, stat_events_d, stat_dropped_q, stat_dropped_d;

  always_comb begin
    stat_events_d  = stat_events_q + 32'(event_done_d);
    stat_dropped_d = stat_dropped_q + 32'(skid_pop && head_drop);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      stat_events_q  <= '0;
      stat_dropped_q <= '0;
    end else begin
      stat_events_q  <= stat_events_d;
      stat_dropped_q <= stat_dropped_d;
    end
  end

  assign stat_events  = stat_events_q;
  assign stat_dropped = stat_dropped_q;
`endif

endmodule

// File: tb/tb_spybuffer_event_reader.sv
// Bench for spybuffer_event_reader: directed framing cases plus random streams,
// checked against a word-by-word framing model of the reader.
module tb_spybuffer_event_reader;

  localparam int MAXW = 4;
  localparam int CW   = $clog2(MAXW + 1);

  logic          clock = 1'b0;
  logic          reset;
  logic [64:0]   buffer_read_data;
  logic          buffer_empty;
  logic          buffer_read_enable;
  logic [64:0]   out_data;
  logic          out_valid;
  logic          out_ready;
  logic          event_done;
  logic [CW-1:0] event_words;
  logic          err_orphan, err_no_footer, err_overflow;
  logic          clear_errors;
`ifdef EVENT_READER_STATS_EN
  logic [31:0]   stat_events, stat_dropped;
`endif

  spybuffer_event_reader #(.DATA_WIDTH(64), .MAX_EVENT_WORDS(MAXW)) dut (
    .clock              (clock),
    .reset              (reset),
    .buffer_read_data   (buffer_read_data),
    .buffer_empty       (buffer_empty),
    .buffer_read_enable (buffer_read_enable),
    .out_data           (out_data),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .event_done         (event_done),
    .event_words        (event_words),
    .err_orphan         (err_orphan),
    .err_no_footer      (err_no_footer),
    .err_overflow       (err_overflow),
    .clear_errors       (clear_errors)
`ifdef EVENT_READER_STATS_EN
    ,
    .stat_events        (stat_events),
    .stat_dropped       (stat_dropped)
`endif
  );

  always #5 clock = ~clock;

  int          n_vec = 0;
  int          n_err = 0;
  int          ready_mode = 0;
  logic        inflight_tb = 1'b0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [64:0] prev_d = '0;

  logic [64:0] stim[$], buf_q[$], exp_out[$], obs_out[$];
  int          exp_done[$], obs_done[$];

  bit          m_in_ev = 0;
  int          m_cnt = 0, m_last_words = 0;
  bit          m_orphan = 0, m_nofoot = 0, m_ovf = 0;
  int unsigned m_events = 0, m_dropped = 0;

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mk_hdr(input logic [55:0] low);
    return {1'b1, 8'hAB, low};
  endfunction
  function automatic logic [64:0] mk_ftr(input logic [55:0] low);
    return {1'b1, 8'hCD, low};
  endfunction
  function automatic logic [64:0] mk_dat(input logic [63:0] d);
    return {1'b0, d};
  endfunction

  // Framing rules applied to one word in buffer order.
  task automatic model_word(input logic [64:0] w);
    bit is_h, is_f, is_d;
    is_d = !w[64];
    is_h = w[64] && (w[63:56] == 8'hAB);
    is_f = w[64] && (w[63:56] == 8'hCD);
    if (!m_in_ev) begin
      if (is_h) begin exp_out.push_back(w); m_in_ev = 1; m_cnt = 0; end
      else begin m_orphan = 1; m_dropped++; end
    end else if (is_h) begin
      m_nofoot = 1; exp_out.push_back(w); m_cnt = 0;
    end else if (is_f) begin
      exp_out.push_back(w); exp_done.push_back(m_cnt);
      m_last_words = m_cnt; m_events++; m_in_ev = 0;
    end else if (is_d) begin
      if (m_cnt < MAXW) begin exp_out.push_back(w); m_cnt++; end
      else begin m_ovf = 1; m_dropped++; end
    end else begin
      exp_out.push_back(w);
    end
  endtask

  task automatic tick();
    logic rd;
    @(negedge clock);
    if (reset) begin
      if (buffer_read_enable) begin
        chk("rd_bound", 65'((int'(dut.skid_count) + int'(inflight_tb)) < 2), 65'(1));
        chk("rd_nonempty", 65'(buffer_empty), 65'(0));
      end
      if (prev_v && !prev_r) begin
        chk("hold_valid", 65'(out_valid), 65'(1));
        chk("hold_data", out_data, prev_d);
      end
      if (out_valid && out_ready) obs_out.push_back(out_data);
      if (event_done) obs_done.push_back(int'(event_words));
    end
    prev_v = out_valid && reset;
    prev_r = out_ready;
    prev_d = out_data;
    rd = buffer_read_enable;
    @(posedge clock);
    #1;
    inflight_tb = rd;
    if (rd && buf_q.size() > 0) buffer_read_data = buf_q.pop_front();
    buffer_empty = (buf_q.size() == 0);
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = !out_ready;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic clr();
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    m_orphan = 0; m_nofoot = 0; m_ovf = 0;
  endtask

  task automatic run_scen(input int mode, input string name);
    int cyc, tail;
    logic [64:0] o;
    exp_out.delete(); obs_out.delete(); exp_done.delete(); obs_done.delete();
    foreach (stim[i]) begin model_word(stim[i]); buf_q.push_back(stim[i]); end
    stim.delete();
    buffer_empty = (buf_q.size() == 0);
    ready_mode = mode;
    out_ready = 1'b1;
    cyc = 0; tail = 0;
    while (cyc < 3000 && tail < 12) begin
      tick();
      cyc++;
      if (buf_q.size() == 0 && obs_out.size() >= exp_out.size()) tail++;
    end
    chk({name, "_drain"}, 65'(cyc < 3000), 65'(1));
    chk({name, "_nwords"}, 65'(obs_out.size()), 65'(exp_out.size()));
    foreach (exp_out[i]) begin
      o = (i < obs_out.size()) ? obs_out[i] : 'x;
      chk($sformatf("%s_word%0d", name, i), o, exp_out[i]);
    end
    chk({name, "_ndone"}, 65'(obs_done.size()), 65'(exp_done.size()));
    foreach (exp_done[i])
      chk($sformatf("%s_done%0d", name, i),
          65'((i < obs_done.size()) ? obs_done[i] : -1), 65'(exp_done[i]));
    chk({name, "_event_words"}, 65'(event_words), 65'(m_last_words));
    chk({name, "_errors"}, 65'({err_orphan, err_no_footer, err_overflow}),
        65'({m_orphan, m_nofoot, m_ovf}));
`ifdef EVENT_READER_STATS_EN
    chk({name, "_stat_events"}, 65'(stat_events), 65'(m_events));
    chk({name, "_stat_dropped"}, 65'(stat_dropped), 65'(m_dropped));
`endif
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int len, r;
    logic [7:0] t;
    reset = 1'b0; buffer_read_data = '0; buffer_empty = 1'b0;
    out_ready = 1'b0; clear_errors = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk("rst_rd_en", 65'(buffer_read_enable), 65'(0));
    chk("rst_out_valid", 65'(out_valid), 65'(0));
    chk("rst_event_done", 65'(event_done), 65'(0));
    chk("rst_event_words", 65'(event_words), 65'(0));
    chk("rst_errors", 65'({err_orphan, err_no_footer, err_overflow}), 65'(0));
    @(posedge clock); #1;
    reset = 1'b1; buffer_empty = 1'b1;

    stim = '{mk_hdr(56'h1), mk_dat(64'h11), mk_dat(64'h22), mk_dat(64'h33), mk_ftr(56'h1)};
    run_scen(0, "basic");
    stim = '{mk_hdr(56'h2), mk_dat(64'h44), mk_dat(64'h55), mk_dat(64'h66), mk_ftr(56'h2)};
    run_scen(1, "toggle");
    clr();
    stim = '{mk_dat(64'h1), mk_ftr(56'h3), mk_hdr(56'h3), mk_dat(64'h77), mk_ftr(56'h4)};
    run_scen(2, "orphan");
    clr();
    stim = '{mk_hdr(56'h5), mk_dat(64'h1), mk_dat(64'h2), mk_hdr(56'h6), mk_dat(64'h3), mk_ftr(56'h5)};
    run_scen(0, "nofooter");
    clr();
    stim = '{mk_hdr(56'h7), mk_dat(64'hA1), mk_dat(64'hA2), mk_dat(64'hA3), mk_dat(64'hA4),
             mk_dat(64'hA5), mk_dat(64'hA6), mk_ftr(56'h7)};
    run_scen(0, "overflow");
    clr();
    chk("clear_errors", 65'({err_orphan, err_no_footer, err_overflow}), 65'(0));

    // Reset in the middle of an event.
    obs_out.delete(); obs_done.delete();
    buf_q = '{mk_hdr(56'h8), mk_dat(64'hB1), mk_dat(64'hB2), mk_dat(64'hB3), mk_ftr(56'h8)};
    buffer_empty = 1'b0; ready_mode = 0; out_ready = 1'b1;
    for (int c = 0; c < 50 && obs_out.size() < 3; c++) tick();
    chk("midrst_progress", 65'(obs_out.size() >= 3), 65'(1));
    reset = 1'b0; buf_q.delete(); buffer_empty = 1'b1;
    tick();
    chk("midrst_rd_en", 65'(buffer_read_enable), 65'(0));
    chk("midrst_out_valid", 65'(out_valid), 65'(0));
    chk("midrst_event_done", 65'(event_done), 65'(0));
    chk("midrst_event_words", 65'(event_words), 65'(0));
    chk("midrst_no_done", 65'(obs_done.size()), 65'(0));
    m_in_ev = 0; m_cnt = 0; m_last_words = 0;
    m_orphan = 0; m_nofoot = 0; m_ovf = 0; m_events = 0; m_dropped = 0;
    reset = 1'b1;
    stim = '{mk_hdr(56'h9), mk_dat(64'hC1), mk_dat(64'hC2), mk_ftr(56'h9)};
    run_scen(0, "after_rst");

    for (int s = 0; s < 6; s++) begin
      clr();
      len = $urandom_range(15, 35);
      for (int k = 0; k < len; k++) begin
        r = $urandom_range(0, 9);
        if (r < 2)       stim.push_back(mk_hdr(56'($urandom)));
        else if (r == 2) stim.push_back(mk_ftr(56'($urandom)));
        else if (r == 3) begin
          t = 8'($urandom_range(0, 255));
          if (t == 8'hAB || t == 8'hCD) t = 8'h00;
          stim.push_back({1'b1, t, 56'($urandom)});
        end else stim.push_back(mk_dat({$urandom, $urandom}));
      end
      run_scen(2, $sformatf("rand%0d", s));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
